burst_sum_checker: RTL and testbench

Downstream consumer of the readback-and-sum stage: it receives the 6-bit output burst (data words followed by one accumulated-sum word) on IN_VALID/IN_DATA. It recomputes the sum of the data words, compares it with the trailing sum word, and reports match, length error, data-word count and maximum data word. The report is a one-cycle OUT_VALID strobe.

---
 rtl/burst_sum_checker.sv | 143 ++++++++++++++
 tb/tb_burst_sum_checker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/burst_sum_checker.sv
// Checks bursts of data words followed by one claimed-sum word and reports match/length status.
// Optional saturating error counter on output err_cnt_o when CHECKER_ERR_CNT_EN is defined.
module burst_sum_checker #(
    parameter int unsigned DATA_W    = 6,
    parameter int unsigned MAX_WORDS = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    output logic              match_o,
    output logic              len_err_o,
    output logic [2:0]        data_cnt_o,
    output logic [DATA_W-1:0] max_out_o,
    output logic              busy_o
`ifdef CHECKER_ERR_CNT_EN
    ,
    output logic [3:0]        err_cnt_o
`endif
);

    localparam logic [2:0] MaxWords = 3'(MAX_WORDS);
    localparam logic [2:0] MaxData  = 3'(MAX_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRecv, StReport} state_e;

    state_e              state_q, state_d;
    logic [DATA_W+2:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [DATA_W-1:0]   last_q, last_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                match_q, match_d;
    logic                len_err_q, len_err_d;
    logic [2:0]          data_cnt_q, data_cnt_d;
    logic [DATA_W-1:0]   max_out_q, max_out_d;

    logic                len_err_c;
    logic                match_c;
    logic [2:0]          cnt_m1_c;

    // At end of burst last_q is the claimed sum; it is never folded into acc_q.
    assign len_err_c = (cnt_q < 3'd2) || (cnt_q > MaxWords);
    assign match_c   = !len_err_c && (acc_q == {3'b000, last_q});
    assign cnt_m1_c  = cnt_q - 3'd1;

`ifdef CHECKER_ERR_CNT_EN
    logic [3:0] err_cnt_q, err_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        max_d      = max_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        match_d    = match_q;
        len_err_d  = len_err_q;
        data_cnt_d = data_cnt_q;
        max_out_d  = max_out_q;
`ifdef CHECKER_ERR_CNT_EN
        err_cnt_d  = err_cnt_q;
`endif
        case (state_q)
            StIdle, StReport: begin
                if (in_valid_i) begin
                    state_d = StRecv;
                    last_d  = in_data_i;
                    cnt_d   = 3'd1;
                    acc_d   = '0;
                    max_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRecv: begin
                if (in_valid_i) begin
                    if (cnt_q < MaxWords) begin
                        acc_d = acc_q + {3'b000, last_q};
                        max_d = (last_q > max_q) ? last_q : max_q;
                    end
                    last_d = in_data_i;
                    cnt_d  = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
                end else begin
                    state_d    = StReport;
                    match_d    = match_c;
                    len_err_d  = len_err_c;
                    data_cnt_d = (cnt_m1_c < MaxData) ? cnt_m1_c : MaxData;
                    max_out_d  = max_q;
`ifdef CHECKER_ERR_CNT_EN
                    if (!match_c && (err_cnt_q != 4'hF)) begin
                        err_cnt_d = err_cnt_q + 4'd1;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            max_q      <= '0;
            last_q     <= '0;
            cnt_q      <= '0;
            match_q    <= 1'b0;
            len_err_q  <= 1'b0;
            data_cnt_q <= '0;
            max_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            max_q      <= max_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            match_q    <= match_d;
            len_err_q  <= len_err_d;
            data_cnt_q <= data_cnt_d;
            max_out_q  <= max_out_d;
        end
    end

`ifdef CHECKER_ERR_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
    assign err_cnt_o = err_cnt_q;
`endif

    assign out_valid_o = (state_q == StReport);
    assign busy_o      = (state_q == StRecv);
    assign match_o     = match_q;
    assign len_err_o   = len_err_q;
    assign data_cnt_o  = data_cnt_q;
    assign max_out_o   = max_out_q;

endmodule

// File: tb/tb_burst_sum_checker.sv
// Bench for burst_sum_checker: queue-based burst model checked every cycle, plus literal reports.
module tb_burst_sum_checker;

    localparam int DW = 6;
    localparam int MW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          match;
    logic          len_err;
    logic [2:0]    data_cnt;
    logic [DW-1:0] max_out;
    logic          busy;
`ifdef CHECKER_ERR_CNT_EN
    logic [3:0]    err_cnt;
`endif

    burst_sum_checker #(.DATA_W(DW), .MAX_WORDS(MW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .match_o     (match),
        .len_err_o   (len_err),
        .data_cnt_o  (data_cnt),
        .max_out_o   (max_out),
        .busy_o      (busy)
`ifdef CHECKER_ERR_CNT_EN
        ,
        .err_cnt_o   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: collect the whole burst, then derive the report by plain arithmetic.
    logic [DW-1:0] burst[$];
    logic          exp_ov = 0, exp_match = 0, exp_len = 0, exp_busy = 0;
    logic [2:0]    exp_cnt = 0;
    logic [DW-1:0] exp_max = 0;
    logic [3:0]    exp_err = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                burst.delete();
                exp_ov = 0; exp_match = 0; exp_len = 0; exp_busy = 0;
                exp_cnt = 0; exp_max = 0; exp_err = 0;
            end else begin
                exp_ov = 0;
                if (in_valid) begin
                    burst.push_back(in_data);
                end else if (burst.size() != 0) begin
                    int n, s, mx;
                    n = burst.size();
                    s = 0;
                    mx = 0;
                    for (int i = 0; i < n - 1 && i < MW - 1; i++) begin
                        s += int'(burst[i]);
                        if (int'(burst[i]) > mx) mx = int'(burst[i]);
                    end
                    exp_ov    = 1;
                    exp_len   = (n < 2) || (n > MW);
                    exp_cnt   = 3'((n - 1 < MW - 1) ? n - 1 : MW - 1);
                    exp_max   = DW'(mx);
                    exp_match = !exp_len && (s == int'(burst[n-1]));
                    if (!exp_match && exp_err != 4'hF) exp_err = exp_err + 4'd1;
                    burst.delete();
                end
                exp_busy = (burst.size() != 0);
            end
        end
    end

    // Every-cycle comparison; reports are also logged for literal checks.
    logic [10:0] rep_log[$];

    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            chk("busy",      32'(busy),      32'(exp_busy));
            chk("match",     32'(match),     32'(exp_match));
            chk("len_err",   32'(len_err),   32'(exp_len));
            chk("data_cnt",  32'(data_cnt),  32'(exp_cnt));
            chk("max_out",   32'(max_out),   32'(exp_max));
`ifdef CHECKER_ERR_CNT_EN
            chk("err_cnt",   32'(err_cnt),   32'(exp_err));
`endif
            if (out_valid === 1'b1) rep_log.push_back({match, len_err, data_cnt, max_out});
        end
    end

    logic [DW-1:0] stim[$];

    task automatic drive_burst();
        foreach (stim[i]) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = stim[i];
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_rep(input string nm, input int m, input int l, input int c,
                              input int x);
        logic [10:0] r;
        if (rep_log.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL %s: got no report expected one", nm);
        end else begin
            r = rep_log.pop_front();
            chk({nm, ".match"},    32'(r[10]),  m);
            chk({nm, ".len_err"},  32'(r[9]),   l);
            chk({nm, ".data_cnt"}, 32'(r[8:6]), c);
            chk({nm, ".max_out"},  32'(r[5:0]), x);
        end
    endtask

    task automatic no_more(input string nm);
        chk({nm, ".extra_reports"}, 32'(rep_log.size()), 0);
        rep_log.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", 32'(busy), 0);
        chk("reset.out_valid", 32'(out_valid), 0);
        rst = 1'b0;

        stim = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd15};
        drive_burst(); idle(3);
        expect_rep("b1", 1, 0, 5, 5); no_more("b1");

        stim = '{6'd7, 6'd7, 6'd13};
        drive_burst(); idle(3);
        expect_rep("b2", 0, 0, 2, 7); no_more("b2");
`ifdef CHECKER_ERR_CNT_EN
        chk("b2.err_cnt", 32'(err_cnt), 1);
`endif

        stim = '{6'd9};
        drive_burst(); idle(3);
        expect_rep("b3", 0, 1, 0, 0); no_more("b3");

        stim = '{6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd6};
        drive_burst(); idle(3);
        expect_rep("b4", 0, 1, 5, 1); no_more("b4");

        // Sum 64 only equals 0 if truncated to 6 bits.
        stim = '{6'd63, 6'd1, 6'd0};
        drive_burst(); idle(3);
        expect_rep("b5", 0, 0, 2, 63); no_more("b5");

        stim = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8};
        drive_burst(); idle(3);
        expect_rep("b6", 0, 1, 5, 5); no_more("b6");

        // Second burst starts in the REPORT cycle of the first.
        stim = '{6'd2, 6'd2, 6'd4};
        drive_burst();
        stim = '{6'd3, 6'd3};
        drive_burst(); idle(3);
        expect_rep("b7", 1, 0, 2, 2);
        expect_rep("b8", 1, 0, 1, 3); no_more("b8");

        stim = '{6'd1, 6'd2, 6'd3};
        foreach (stim[i]) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = stim[i];
        end
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst.busy",  32'(busy), 0);
        chk("rst.match", 32'(match), 0);
        chk("rst.max",   32'(max_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(4);
        no_more("rst");

        stim = '{6'd5, 6'd5};
        drive_burst(); idle(3);
        expect_rep("b9", 1, 0, 1, 5); no_more("b9");

        idle(2);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
